// File: rtl/unified_mem_arbiter_pkg.sv
// mem_arb_pkg: shared FSM state encoding and grant ids for the fetch/data memory arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;
   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_D  = 1'b1;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: CPU fetch/data ports and memory bus; slave = arbiter side, master = CPU+memory side.
interface unified_mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic              if_valid;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_done;
   logic              d_valid;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_done;
   logic              err;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   modport slave (
      input  if_valid, if_addr, d_valid, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      output if_rdata, if_done, d_rdata, d_done, err, mem_req, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output if_valid, if_addr, d_valid, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_done, d_rdata, d_done, err, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/unified_mem_arbiter_watchdog.sv
// mem_arb_watchdog: saturating ACCESS-cycle counter, cleared outside ACCESS; expires in the TIMEOUT-th cycle.
module mem_arb_watchdog #(parameter int TIMEOUT = 255) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [W-1:0] SAT  = W'(TIMEOUT);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else if (clr_i) cnt_q <= '0;
      else if (en_i && cnt_q != SAT) cnt_q <= cnt_q + W'(1);
   // cnt_q holds completed ACCESS cycles, so the TIMEOUT-th cycle is the one showing TIMEOUT-1
   assign expired_o = (TIMEOUT != 0) && en_i && cnt_q == LAST;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one variable-latency memory between fetch and data ports, data-first with fetch starvation guard.
module unified_mem_arbiter import mem_arb_pkg::*; #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_DATA_RUN = 4,
   parameter int TIMEOUT      = 255
) (
   input logic clk,
   input logic reset,
   unified_mem_arbiter_if.slave bus
);
   localparam int RW = $clog2(MAX_DATA_RUN + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DATA_RUN);
   state_t            state_q;
   logic              gnt_q, we_q, err_q, mem_req_q, if_done_q, d_done_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic [RW-1:0]     run_q;
   logic              d_win, expired;
   assign d_win = bus.d_valid & (~bus.if_valid | (run_q < RUN_MAX));
   mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (state_q != ST_ACCESS),
      .en_i      (state_q == ST_ACCESS),
      .expired_o (expired)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q   <= ST_IDLE;
         gnt_q     <= GNT_IF;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         mem_req_q <= 1'b0;
         if_done_q <= 1'b0;
         d_done_q  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         run_q     <= '0;
      end else begin
         if_done_q <= 1'b0;
         d_done_q  <= 1'b0;
         err_q     <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // the run only counts data grants made while a fetch is waiting
               if (!bus.if_valid) run_q <= '0;
               if (d_win) begin
                  gnt_q     <= GNT_D;
                  we_q      <= bus.d_we;
                  addr_q    <= bus.d_addr;
                  wdata_q   <= bus.d_wdata;
                  mem_req_q <= 1'b1;
                  state_q   <= ST_ACCESS;
                  if (bus.if_valid) run_q <= run_q + RW'(1);
               end else if (bus.if_valid) begin
                  gnt_q     <= GNT_IF;
                  we_q      <= 1'b0;
                  addr_q    <= bus.if_addr;
                  wdata_q   <= '0;
                  mem_req_q <= 1'b1;
                  run_q     <= '0;
                  state_q   <= ST_ACCESS;
               end
            end
            ST_ACCESS:
               if (bus.mem_ack || expired) begin
                  mem_req_q <= 1'b0;
                  rdata_q   <= (bus.mem_ack && !we_q) ? bus.mem_rdata : '0;
                  err_q     <= !bus.mem_ack;
                  if_done_q <= gnt_q == GNT_IF;
                  d_done_q  <= gnt_q == GNT_D;
                  state_q   <= ST_RESP;
               end
            default: state_q <= ST_IDLE;
         endcase
      end
   assign bus.if_done   = if_done_q;
   assign bus.d_done    = d_done_q;
   assign bus.err       = err_q;
   assign bus.if_rdata  = if_done_q ? rdata_q : '0;
   assign bus.d_rdata   = d_done_q ? rdata_q : '0;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_req_q & we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed checks of grant order, latency, stores, watchdog and reset for unified_mem_arbiter.
module tb_unified_mem_arbiter;
   import mem_arb_pkg::*;
   logic clk;
   logic reset;
   int   compared = 0;
   int   failed = 0;
   unified_mem_arbiter_if bus ();
   unified_mem_arbiter #(.MAX_DATA_RUN(4), .TIMEOUT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   initial begin
      logic is_f;
      reset = 1'b1;
      bus.if_valid = 0; bus.if_addr = '0;
      bus.d_valid = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.mem_ack = 0; bus.mem_rdata = '0;
      tick(); tick();
      chk("rst_mem_req", 32'(bus.mem_req), 0);
      chk("rst_dones", {30'd0, bus.if_done, bus.d_done}, 0);
      chk("rst_err", 32'(bus.err), 0);
      reset = 1'b0;
      tick();
      // 1: fetch alone, memory acks one cycle after request
      bus.if_valid = 1; bus.if_addr = 32'h10;
      tick();
      chk("t1_req", {31'd0, bus.mem_req}, 1);
      chk("t1_addr", bus.mem_addr, 32'h10);
      chk("t1_we", 32'(bus.mem_we), 0);
      tick();
      chk("t1_no_early_done", 32'(bus.if_done), 0);
      bus.mem_ack = 1; bus.mem_rdata = 32'h00500093;
      tick();
      chk("t1_if_done", 32'(bus.if_done), 1);
      chk("t1_if_rdata", bus.if_rdata, 32'h00500093);
      chk("t1_err", 32'(bus.err), 0);
      chk("t1_d_done", 32'(bus.d_done), 0);
      chk("t1_req_low", 32'(bus.mem_req), 0);
      bus.mem_ack = 0; bus.if_valid = 0;
      tick();
      chk("t1_done_pulse", 32'(bus.if_done), 0);
      // 2: simultaneous requests, data first then fetch
      bus.d_valid = 1; bus.d_we = 0; bus.d_addr = 32'h200;
      bus.if_valid = 1; bus.if_addr = 32'h14;
      tick();
      chk("t2_addr_d", bus.mem_addr, 32'h200);
      bus.mem_ack = 1; bus.mem_rdata = 32'hAAAA0001;
      tick();
      chk("t2_d_done", 32'(bus.d_done), 1);
      chk("t2_d_rdata", bus.d_rdata, 32'hAAAA0001);
      chk("t2_if_done_0", 32'(bus.if_done), 0);
      bus.mem_ack = 0; bus.d_valid = 0;
      tick();
      chk("t2_idle_dones", {30'd0, bus.if_done, bus.d_done}, 0);
      tick();
      chk("t2_addr_if", bus.mem_addr, 32'h14);
      chk("t2_req_if", 32'(bus.mem_req), 1);
      bus.mem_ack = 1; bus.mem_rdata = 32'h11112222;
      tick();
      chk("t2_if_done", 32'(bus.if_done), 1);
      chk("t2_if_rdata", bus.if_rdata, 32'h11112222);
      chk("t2_d_done_0", 32'(bus.d_done), 0);
      bus.mem_ack = 0; bus.if_valid = 0;
      tick();
      // 3: data held for 10 loads with fetch waiting; fetch wins after the 4th
      bus.d_valid = 1; bus.d_we = 0; bus.d_addr = 32'h400;
      bus.if_valid = 1; bus.if_addr = 32'h18;
      bus.mem_ack = 1; bus.mem_rdata = 32'h0BADF00D;
      for (int i = 0; i < 11; i++) begin
         is_f = (i == 4);
         tick();
         chk($sformatf("t3_addr_%0d", i), bus.mem_addr, is_f ? 32'h18 : 32'h400);
         tick();
         chk($sformatf("t3_done_%0d", i), {30'd0, bus.if_done, bus.d_done}, is_f ? 32'd2 : 32'd1);
         if (is_f) bus.if_valid = 0;
         if (i == 10) bus.d_valid = 0;
         tick();
      end
      bus.mem_ack = 0;
      // 4: store uses latched address/data, returns zero read data
      bus.d_valid = 1; bus.d_we = 1; bus.d_addr = 32'h300; bus.d_wdata = 32'hDEADBEEF;
      tick();
      chk("t4_we", 32'(bus.mem_we), 1);
      chk("t4_wdata", bus.mem_wdata, 32'hDEADBEEF);
      chk("t4_addr", bus.mem_addr, 32'h300);
      bus.d_addr = 32'h999; bus.d_wdata = 32'h0;
      tick();
      chk("t4_we_hold", 32'(bus.mem_we), 1);
      chk("t4_wdata_hold", bus.mem_wdata, 32'hDEADBEEF);
      chk("t4_addr_latched", bus.mem_addr, 32'h300);
      bus.mem_ack = 1; bus.mem_rdata = 32'h12345678;
      tick();
      chk("t4_d_done", 32'(bus.d_done), 1);
      chk("t4_d_rdata", bus.d_rdata, 0);
      bus.mem_ack = 0; bus.d_valid = 0; bus.d_we = 0;
      tick();
      // 5: memory never acks, watchdog aborts after 8 request cycles
      bus.d_valid = 1; bus.d_addr = 32'h500;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("t5_req_%0d", i), {30'd0, bus.mem_req, bus.d_done}, 32'd2);
      end
      tick();
      chk("t5_d_done", 32'(bus.d_done), 1);
      chk("t5_err", 32'(bus.err), 1);
      chk("t5_d_rdata", bus.d_rdata, 0);
      chk("t5_req_low", 32'(bus.mem_req), 0);
      bus.d_valid = 0;
      tick();
      chk("t5_err_pulse", 32'(bus.err), 0);
      bus.if_valid = 1; bus.if_addr = 32'h20;
      tick();
      chk("t5_next_req", 32'(bus.mem_req), 1);
      bus.mem_ack = 1; bus.mem_rdata = 32'hCAFE0000;
      tick();
      chk("t5_next_done", {30'd0, bus.if_done, bus.err}, 32'd2);
      chk("t5_next_rdata", bus.if_rdata, 32'hCAFE0000);
      bus.mem_ack = 0; bus.if_valid = 0;
      tick();
      // 5b: ack arriving in the expiry cycle wins without error
      bus.d_valid = 1; bus.d_addr = 32'h600;
      for (int i = 0; i < 8; i++) tick();
      bus.mem_ack = 1; bus.mem_rdata = 32'h600D600D;
      tick();
      chk("t5b_done_noerr", {30'd0, bus.d_done, bus.err}, 32'd2);
      chk("t5b_rdata", bus.d_rdata, 32'h600D600D);
      bus.mem_ack = 0; bus.d_valid = 0;
      tick();
      // 6: reset mid-ACCESS, pending fetch re-granted afterwards
      bus.if_valid = 1; bus.if_addr = 32'h24;
      tick();
      chk("t6_req_before", 32'(bus.mem_req), 1);
      #2 reset = 1'b1;
      #1;
      chk("t6_req_async", 32'(bus.mem_req), 0);
      chk("t6_outs_async", {29'd0, bus.if_done, bus.d_done, bus.err}, 0);
      tick();
      reset = 1'b0;
      chk("t6_idle_after", 32'(bus.mem_req), 0);
      tick();
      chk("t6_regrant_req", 32'(bus.mem_req), 1);
      chk("t6_regrant_addr", bus.mem_addr, 32'h24);
      bus.mem_ack = 1; bus.mem_rdata = 32'h00000013;
      tick();
      chk("t6_if_done", 32'(bus.if_done), 1);
      chk("t6_if_rdata", bus.if_rdata, 32'h00000013);
      bus.mem_ack = 0; bus.if_valid = 0;
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule
